// File: rtl/flex_updown_counter.sv
// ============================================================================
// flex_updown_counter
//
// Purpose:
//   Up/down counter with a programmable upper limit. At the limit the count
//   either wraps or saturates. An optional prescaler divides the enabled
//   cycles, so the count moves once every (prescale_val+1) enabled cycles.
//   Priority within a cycle is clear > load > step > hold.
//
// Configuration:
//   FLEX_CNT_PRESCALE_EN - when defined, the prescaler register is built in.
//                          When undefined, prescale_val is ignored and the
//                          counter steps on every enabled cycle.
//
// Parameters:
//   NUM_CNT_BITS  - counter width N
//   PRESCALE_BITS - prescaler width P
//
// Ports:
//   clk           in   system clock; all state changes on the rising edge
//   n_rst         in   asynchronous active-low reset
//   clear         in   synchronous clear of count, prescaler and flags
//   load          in   synchronous load of load_val (prescaler restarts)
//   load_val      in   [N] value taken on load
//   count_enable  in   advances the prescaler and permits count steps
//   count_down    in   step direction: 0 = up, 1 = down
//   saturate      in   1 = hold at the limit, 0 = wrap
//   rollover_val  in   [N] upper count limit (0 freezes the count)
//   prescale_val  in   [P] enabled cycles per step, minus one
//   count_out     out  [N] registered count
//   rollover_flag out  registered, count_out == rollover_val != 0
//   bottom_flag   out  registered, count_out == 1
//   wrap_pulse    out  registered one-cycle pulse after a wrapping step
// ============================================================================
module flex_updown_counter #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int PRESCALE_BITS = 4
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     load,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic                     count_enable,
    input  logic                     count_down,
    input  logic                     saturate,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    input  logic [PRESCALE_BITS-1:0] prescale_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     bottom_flag,
    output logic                     wrap_pulse
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    rollover_flag_q, rollover_flag_d;
    logic                    bottom_flag_q, bottom_flag_d;
    logic                    wrap_pulse_q, wrap_pulse_d;
    logic                    step;

`ifdef FLEX_CNT_PRESCALE_EN
    localparam logic [PRESCALE_BITS-1:0] PRE_ZERO = '0;
    localparam logic [PRESCALE_BITS-1:0] PRE_ONE  = PRESCALE_BITS'(1);

    logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;

    // The step fires on the enabled cycle that finds the prescaler at its
    // terminal value; load and clear restart the prescaler from zero.
    assign step = count_enable && (prescale_q == prescale_val);

    always_comb begin
        prescale_d = prescale_q;
        if (clear || load) begin
            prescale_d = PRE_ZERO;
        end else if (count_enable) begin
            prescale_d = step ? PRE_ZERO : prescale_q + PRE_ONE;
        end
    end
`else
    // Port kept for drop-in compatibility; reduced to a signal that is
    // intentionally left unused.
    logic unused_prescale_val;
    assign unused_prescale_val = ^prescale_val;

    assign step = count_enable;
`endif

    // Next-state for the count and the flags. The flags are derived from
    // count_d so they land in the same cycle as the count they describe.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        count_d      = count_q;
        wrap_pulse_d = 1'b0;

        if (clear) begin
            count_d = CNT_ZERO;
        end else if (load) begin
            count_d = load_val;
        end else if (step && (rollover_val != CNT_ZERO)) begin
            if (!count_down) begin
                if (count_q < rollover_val) begin
                    count_d = count_q + CNT_ONE;
                end else if (!saturate) begin
                    // At or above the limit (e.g. after a large load).
                    count_d      = CNT_ONE;
                    wrap_pulse_d = 1'b1;
                end
            end else begin
                if (count_q > CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                end else if (!saturate) begin
                    // Bottom of the range is 1; a count of 0 wraps too.
                    count_d      = rollover_val;
                    wrap_pulse_d = 1'b1;
                end
            end
        end

        rollover_flag_d = (count_d == rollover_val) && (rollover_val != CNT_ZERO);
        bottom_flag_d   = (count_d == CNT_ONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q         <= CNT_ZERO;
            rollover_flag_q <= 1'b0;
            bottom_flag_q   <= 1'b0;
            wrap_pulse_q    <= 1'b0;
        end else begin
            count_q         <= count_d;
            rollover_flag_q <= rollover_flag_d;
            bottom_flag_q   <= bottom_flag_d;
            wrap_pulse_q    <= wrap_pulse_d;
        end
    end

`ifdef FLEX_CNT_PRESCALE_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prescale_q <= PRE_ZERO;
        end else begin
            prescale_q <= prescale_d;
        end
    end
`endif

    assign count_out     = count_q;
    assign rollover_flag = rollover_flag_q;
    assign bottom_flag   = bottom_flag_q;
    assign wrap_pulse    = wrap_pulse_q;

endmodule

// File: tb/tb_flex_updown_counter.sv
// ============================================================================
// tb_flex_updown_counter
//
// Directed bench for flex_updown_counter (N = 4, P = 4). Each clocked step
// pushes the expected count and flags onto a scoreboard queue; the entry is
// popped and compared one time unit after the rising edge. Expectations for
// the prescale sequence depend on whether FLEX_CNT_PRESCALE_EN is defined.
// ============================================================================
module tb_flex_updown_counter;

    typedef struct packed {
        logic [3:0] cnt;
        logic       roll;
        logic       bot;
        logic       wrap;
    } exp_t;

    logic       clk;
    logic       n_rst;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       count_enable;
    logic       count_down;
    logic       saturate;
    logic [3:0] rollover_val;
    logic [3:0] prescale_val;
    logic [3:0] count_out;
    logic       rollover_flag;
    logic       bottom_flag;
    logic       wrap_pulse;

    int tests_run = 0;
    int tests_failed = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    logic [3:0] pre_cnt [8];
    logic       pre_en  [8];

    flex_updown_counter #(
        .NUM_CNT_BITS (4),
        .PRESCALE_BITS(4)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .count_down   (count_down),
        .saturate     (saturate),
        .rollover_val (rollover_val),
        .prescale_val (prescale_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .bottom_flag  (bottom_flag),
        .wrap_pulse   (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Push the expectation, advance one edge, then pop and compare.
    task automatic tick(input logic [3:0] ec, input logic er, input logic eb,
                        input logic ew, input string tag);
        exp_t e;
        string t;
        exp_q.push_back('{cnt: ec, roll: er, bot: eb, wrap: ew});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, " count"}, count_out, e.cnt);
            chk({t, " roll"}, {3'b0, rollover_flag}, {3'b0, e.roll});
            chk({t, " bot"}, {3'b0, bottom_flag}, {3'b0, e.bot});
            chk({t, " wrap"}, {3'b0, wrap_pulse}, {3'b0, e.wrap});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " count"}, count_out, 4'd0);
        chk({tag, " roll"}, {3'b0, rollover_flag}, 4'd0);
        chk({tag, " bot"}, {3'b0, bottom_flag}, 4'd0);
        chk({tag, " wrap"}, {3'b0, wrap_pulse}, 4'd0);
    endtask

    initial begin
        pre_en = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef FLEX_CNT_PRESCALE_EN
        pre_cnt = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
`else
        pre_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd6};
`endif

        n_rst        = 1'b0;
        clear        = 1'b0;
        load         = 1'b0;
        load_val     = 4'd0;
        count_enable = 1'b0;
        count_down   = 1'b0;
        saturate     = 1'b0;
        rollover_val = 4'd5;
        prescale_val = 4'd0;

        #2;
        chk_zero("reset");
        #6;
        n_rst = 1'b1;

        // Up wrap: limit 5, step every cycle.
        count_enable = 1'b1;
        tick(4'd1, 1'b0, 1'b1, 1'b0, "upwrap1");
        tick(4'd2, 1'b0, 1'b0, 1'b0, "upwrap2");
        tick(4'd3, 1'b0, 1'b0, 1'b0, "upwrap3");
        tick(4'd4, 1'b0, 1'b0, 1'b0, "upwrap4");
        tick(4'd5, 1'b1, 1'b0, 1'b0, "upwrap5");
        tick(4'd1, 1'b0, 1'b1, 1'b1, "upwrap_ret");
        tick(4'd2, 1'b0, 1'b0, 1'b0, "upwrap_after");

        // Down saturate from a load of 3.
        load = 1'b1; load_val = 4'd3; count_down = 1'b1; saturate = 1'b1;
        tick(4'd3, 1'b0, 1'b0, 1'b0, "dsat_load");
        load = 1'b0;
        tick(4'd2, 1'b0, 1'b0, 1'b0, "dsat2");
        tick(4'd1, 1'b0, 1'b1, 1'b0, "dsat1");
        tick(4'd1, 1'b0, 1'b1, 1'b0, "dsat1_hold_a");
        tick(4'd1, 1'b0, 1'b1, 1'b0, "dsat1_hold_b");

        // Clear beats load in the same cycle.
        clear = 1'b1; load = 1'b1; load_val = 4'd6;
        tick(4'd0, 1'b0, 1'b0, 1'b0, "prio_clr_ld");
        clear = 1'b0; load = 1'b0;

        // Prescale by 3 with enable dropped for two cycles mid-prescale.
        count_down = 1'b0; saturate = 1'b0; rollover_val = 4'd7; prescale_val = 4'd2;
        for (int i = 0; i < 8; i++) begin
            count_enable = pre_en[i];
            tick(pre_cnt[i], 1'b0, (pre_cnt[i] == 4'd1), 1'b0, $sformatf("presc%0d", i));
        end
        count_enable = 1'b1;

        // Loaded value above the limit: wrap, then saturate.
        prescale_val = 4'd0; rollover_val = 4'd4;
        load = 1'b1; load_val = 4'd9;
        tick(4'd9, 1'b0, 1'b0, 1'b0, "above_load_w");
        load = 1'b0;
        tick(4'd1, 1'b0, 1'b1, 1'b1, "above_wrap");
        saturate = 1'b1; load = 1'b1;
        tick(4'd9, 1'b0, 1'b0, 1'b0, "above_load_s");
        load = 1'b0;
        tick(4'd9, 1'b0, 1'b0, 1'b0, "above_sat");

        // Async reset between edges at count 3.
        saturate = 1'b0; rollover_val = 4'd5; clear = 1'b1;
        tick(4'd0, 1'b0, 1'b0, 1'b0, "ar_clear");
        clear = 1'b0;
        tick(4'd1, 1'b0, 1'b1, 1'b0, "ar_cnt1");
        tick(4'd2, 1'b0, 1'b0, 1'b0, "ar_cnt2");
        tick(4'd3, 1'b0, 1'b0, 1'b0, "ar_cnt3");
        #2;
        n_rst = 1'b0;
        #1;
        chk_zero("async_rst");
        #1;
        n_rst = 1'b1;
        rollover_val = 4'd0;
        tick(4'd0, 1'b0, 1'b0, 1'b0, "rv0_a");
        tick(4'd0, 1'b0, 1'b0, 1'b0, "rv0_b");
        tick(4'd0, 1'b0, 1'b0, 1'b0, "rv0_c");

        // Reset mid-prescale leaves a full prescale period before the first step.
        rollover_val = 4'd5; prescale_val = 4'd2;
        tick(`ifdef FLEX_CNT_PRESCALE_EN 4'd0 `else 4'd1 `endif, 1'b0,
             `ifdef FLEX_CNT_PRESCALE_EN 1'b0 `else 1'b1 `endif, 1'b0, "rst_pre_a");
        #2;
        n_rst = 1'b0;
        #1;
        chk_zero("rst_pre_rst");
        #1;
        n_rst = 1'b1;
`ifdef FLEX_CNT_PRESCALE_EN
        tick(4'd0, 1'b0, 1'b0, 1'b0, "rst_pre_b");
        tick(4'd0, 1'b0, 1'b0, 1'b0, "rst_pre_c");
        tick(4'd1, 1'b0, 1'b1, 1'b0, "rst_pre_d");
`else
        tick(4'd1, 1'b0, 1'b1, 1'b0, "rst_pre_b");
        tick(4'd2, 1'b0, 1'b0, 1'b0, "rst_pre_c");
        tick(4'd3, 1'b0, 1'b0, 1'b0, "rst_pre_d");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
